// File: rtl/mrd_pkg.sv
// Shared types, widths and helpers for the MRD iterative detector.
// The accumulator width and saturation bounds track the default matrix order and element width.
package mrd_pkg;

    localparam int MRD_DIM   = 16;
    localparam int MRD_W     = 8;
    localparam int MRD_FRAC  = 4;
    localparam int MRD_ACC_W = 2*MRD_W + $clog2(MRD_DIM) + 2;

    typedef enum logic [1:0] {IDLE, RES, UPD, FIN} state_t;

    localparam logic signed [MRD_ACC_W-1:0] MRD_SAT_HI = MRD_ACC_W'((1 << (MRD_W-1)) - 1);
    localparam logic signed [MRD_ACC_W-1:0] MRD_SAT_LO = ~MRD_SAT_HI;

    // Element index inside a row-major flattened matrix.
    function automatic int flat_idx(input int row, input int col, input int dim);
        return row*dim + col;
    endfunction

    function automatic logic signed [MRD_W-1:0] sat_w(input logic signed [MRD_ACC_W-1:0] v);
        if (v > MRD_SAT_HI)
            return MRD_SAT_HI[MRD_W-1:0];
        else if (v < MRD_SAT_LO)
            return MRD_SAT_LO[MRD_W-1:0];
        else
            return v[MRD_W-1:0];
    endfunction

endpackage

// File: rtl/mrd_row_dot.sv
// One-row dot product: DIMENSION signed multiplies reduced into a wide accumulator,
// combined with a preload term (added, or with the sum subtracted from it), then floored by FRAC.
module mrd_row_dot import mrd_pkg::*; #(
    parameter int DIMENSION = MRD_DIM,
    parameter int WIDTH     = MRD_W,
    parameter int FRAC      = MRD_FRAC,
    parameter int ACC_W     = MRD_ACC_W
) (
    input  logic [DIMENSION*WIDTH-1:0] i_row,
    input  logic [DIMENSION*WIDTH-1:0] i_vec,
    input  logic [ACC_W-1:0]           i_pre,
    input  logic                       i_neg,
    output logic [ACC_W-1:0]           o_acc
);

    logic signed [WIDTH-1:0]   w_a;
    logic signed [WIDTH-1:0]   w_v;
    logic signed [2*WIDTH-1:0] w_prod;
    logic signed [ACC_W-1:0]   w_sum;
    logic signed [ACC_W-1:0]   w_tot;

    // The sequential sum is flattened into a balanced adder tree by synthesis.
    always_comb begin
        w_a    = '0;
        w_v    = '0;
        w_prod = '0;
        w_sum  = '0;
        for (int j = 0; j < DIMENSION; j++) begin
            w_a    = i_row[j*WIDTH +: WIDTH];
            w_v    = i_vec[j*WIDTH +: WIDTH];
            w_prod = w_a * w_v;
            w_sum  = w_sum + {{(ACC_W-2*WIDTH){w_prod[2*WIDTH-1]}}, w_prod};
        end
        w_tot = i_neg ? (i_pre - w_sum) : (i_pre + w_sum);
        o_acc = w_tot >>> FRAC;
    end

endmodule

// File: rtl/mrd_iteration_engine.sv
// Time-multiplexed Richardson iteration x <- x + M(b - Ax): one matrix row per clock,
// a residual pass (RES) followed by an update pass (UPD) per iteration.
module mrd_iteration_engine import mrd_pkg::*; #(
    parameter int DIMENSION = MRD_DIM,
    parameter int WIDTH     = MRD_W,
    parameter int FRAC      = MRD_FRAC,
    parameter int ITER      = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [DIMENSION*DIMENSION*WIDTH-1:0] A_flat,
    input  logic [DIMENSION*DIMENSION*WIDTH-1:0] M_flat,
    input  logic [DIMENSION*WIDTH-1:0]           b,
    input  logic [DIMENSION*WIDTH-1:0]           x0,
    output logic                                 busy,
    output logic                                 done,
    output logic [DIMENSION*WIDTH-1:0]           x_final
);

    localparam int ROW_W = $clog2(DIMENSION);
    localparam int IT_W  = (ITER < 2) ? 1 : $clog2(ITER + 1);
    localparam int ACC_W = MRD_ACC_W;

    state_t                     r_state;
    logic [ROW_W-1:0]           r_row;
    logic [IT_W-1:0]            r_it;
    logic [DIMENSION*WIDTH-1:0] r_b;
    logic [DIMENSION*WIDTH-1:0] r_x;
    logic [DIMENSION*WIDTH-1:0] r_r;
    logic [DIMENSION*WIDTH-1:0] r_x_final;
    logic                       r_busy;
    logic                       r_done;

    logic [DIMENSION*WIDTH-1:0] w_a_row;
    logic [DIMENSION*WIDTH-1:0] w_m_row;
    logic [DIMENSION*WIDTH-1:0] w_op_row;
    logic [DIMENSION*WIDTH-1:0] w_vec;
    logic [WIDTH-1:0]           w_pre_el;
    logic [ACC_W-1:0]           w_pre_ext;
    logic [ACC_W-1:0]           w_pre;
    logic [ACC_W-1:0]           w_acc;
    logic [WIDTH-1:0]           w_sat;
    logic                       w_upd;
    logic                       w_last_row;

    assign w_upd      = (r_state == UPD);
    assign w_last_row = (r_row == ROW_W'(DIMENSION - 1));
    assign w_a_row    = A_flat[flat_idx(int'(r_row), 0, DIMENSION)*WIDTH +: DIMENSION*WIDTH];
    assign w_m_row    = M_flat[flat_idx(int'(r_row), 0, DIMENSION)*WIDTH +: DIMENSION*WIDTH];
    assign w_op_row   = w_upd ? w_m_row : w_a_row;
    assign w_vec      = w_upd ? r_r : r_x;

    // Both passes share one form: sat((pre<<<FRAC +/- dot) >>> FRAC), with pre = x[i] or b[i].
    // Adding x[i] before the floor is exact because x[i]<<<FRAC has no fractional part.
    assign w_pre_el   = w_upd ? r_x[r_row*WIDTH +: WIDTH] : r_b[r_row*WIDTH +: WIDTH];
    assign w_pre_ext  = {{(ACC_W-WIDTH){w_pre_el[WIDTH-1]}}, w_pre_el};
    assign w_pre      = w_pre_ext <<< FRAC;

    mrd_row_dot #(
        .DIMENSION (DIMENSION),
        .WIDTH     (WIDTH),
        .FRAC      (FRAC),
        .ACC_W     (ACC_W)
    ) u_row_dot (
        .i_row (w_op_row),
        .i_vec (w_vec),
        .i_pre (w_pre),
        .i_neg (~w_upd),
        .o_acc (w_acc)
    );

    assign w_sat = sat_w(w_acc);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_row     <= '0;
            r_it      <= '0;
            r_b       <= '0;
            r_x       <= '0;
            r_r       <= '0;
            r_x_final <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_b     <= b;
                        r_x     <= x0;
                        r_row   <= '0;
                        r_it    <= '0;
                        r_busy  <= 1'b1;
                        r_state <= (ITER == 0) ? FIN : RES;
                    end
                end
                RES: begin
                    r_r[r_row*WIDTH +: WIDTH] <= w_sat;
                    if (w_last_row) begin
                        r_row   <= '0;
                        r_state <= UPD;
                    end else begin
                        r_row <= r_row + 1'b1;
                    end
                end
                UPD: begin
                    r_x[r_row*WIDTH +: WIDTH] <= w_sat;
                    if (w_last_row) begin
                        r_row   <= '0;
                        r_it    <= r_it + 1'b1;
                        r_state <= (int'(r_it) + 1 == ITER) ? FIN : RES;
                    end else begin
                        r_row <= r_row + 1'b1;
                    end
                end
                FIN: begin
                    r_x_final <= r_x;
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign x_final = r_x_final;

endmodule
